// File: rtl/en2edge.sv
// Turns single-cycle enable strobes into width-controlled pulses on a level output.
// Strobes that arrive while a pulse is in progress are queued in a saturating counter.
module en2edge #(
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned PEND_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 trig_i,
  input  logic [CNT_WIDTH-1:0] high_len_i,
  input  logic [CNT_WIDTH-1:0] low_len_i,
  output logic                 data_o,
  output logic                 done_o,
  output logic                 ovf_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  localparam logic [PEND_WIDTH-1:0] PendMax = '1;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  timer_q, timer_d;
  logic [PEND_WIDTH-1:0] pend_q, pend_d;
  logic                  data_q, data_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;

  logic [CNT_WIDTH-1:0]  hi_load, lo_load;
  logic                  inc, dec, consumed;

  // A programmed length of 0 behaves like 1, so the reload value never wraps.
  assign hi_load = (high_len_i == '0) ? '0 : high_len_i - CNT_WIDTH'(1);
  assign lo_load = (low_len_i == '0) ? '0 : low_len_i - CNT_WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    dec      = 1'b0;
    consumed = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pend_q != '0) begin
          state_d = StHigh;
          timer_d = hi_load;
          dec     = 1'b1;
        end else if (trig_i) begin
          state_d  = StHigh;
          timer_d  = hi_load;
          consumed = 1'b1;
        end
      end
      StHigh: begin
        if (timer_q == '0) begin
          state_d = StLow;
          timer_d = lo_load;
        end else begin
          timer_d = timer_q - CNT_WIDTH'(1);
        end
      end
      StLow: begin
        if (timer_q == '0) begin
          if (pend_q != '0) begin
            state_d = StHigh;
            timer_d = hi_load;
            dec     = 1'b1;
          end else if (trig_i) begin
            state_d  = StHigh;
            timer_d  = hi_load;
            consumed = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q - CNT_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign inc = trig_i && !consumed;

  always_comb begin
    pend_d = pend_q;
    ovf_d  = 1'b0;
    if (inc && !dec) begin
      if (pend_q == PendMax) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_WIDTH'(1);
      end
    end else if (dec && !inc) begin
      pend_d = pend_q - PEND_WIDTH'(1);
    end
  end

  assign data_d = (state_d == StHigh);
  assign done_d = (state_q == StHigh) && (timer_q == '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      timer_q <= '0;
      pend_q  <= '0;
      data_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_o = data_q;
  assign done_o = done_q;
  assign ovf_o  = ovf_q;
  assign busy_o = (state_q != StIdle) || (pend_q != '0);

endmodule

// File: tb/tb_en2edge.sv
// Directed bench for en2edge: per-cycle expected traces computed by hand.
module tb_en2edge;

  logic       clk;
  logic       rst_n;
  logic       trig;
  logic [7:0] high_len;
  logic [7:0] low_len;
  logic       data, done, ovf, busy;

  int nvec;
  int nerr;

  en2edge #(
    .CNT_WIDTH (8),
    .PEND_WIDTH(4)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .trig_i    (trig),
    .high_len_i(high_len),
    .low_len_i (low_len),
    .data_o    (data),
    .done_o    (done),
    .ovf_o     (ovf),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b1;
    trig  = 1'b0;
    high_len = 8'd1;
    low_len  = 8'd1;
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if ({data, done, ovf, busy} !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_outputs: got %b want 0000", {data, done, ovf, busy});
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [15:0] tv, ed, edn, eb;
    tv = 16'h0001; ed = 16'h000E; edn = 16'h0010; eb = 16'h003E;
    high_len = 8'd3; low_len = 8'd2;
    for (int c = 0; c < 8; c++) begin
      trig = tv[c];
      @(negedge clk);
      nvec++;
      if ({data, done, busy} !== {ed[c], edn[c], eb[c]}) begin
        nerr++;
        $display("FAIL single c%0d: got data/done/busy=%b want %b", c, {data, done, busy},
                 {ed[c], edn[c], eb[c]});
      end
      @(posedge clk);
      #1;
    end
    trig = 1'b0;
  endtask

  task automatic test_burst();
    logic [15:0] tv, ed, edn;
    tv = 16'h0007; ed = 16'h01B6; edn = 16'h0248;
    high_len = 8'd2; low_len = 8'd1;
    for (int c = 0; c < 12; c++) begin
      trig = tv[c];
      @(negedge clk);
      nvec++;
      if ({data, done} !== {ed[c], edn[c]}) begin
        nerr++;
        $display("FAIL burst c%0d: got data/done=%b want %b", c, {data, done}, {ed[c], edn[c]});
      end
      @(posedge clk);
      #1;
    end
    trig = 1'b0;
  endtask

  task automatic test_zero_len();
    logic [15:0] tv, ed, edn;
    tv = 16'h0003; ed = 16'h000A; edn = 16'h0014;
    high_len = 8'd0; low_len = 8'd0;
    for (int c = 0; c < 7; c++) begin
      trig = tv[c];
      @(negedge clk);
      nvec++;
      if ({data, done} !== {ed[c], edn[c]}) begin
        nerr++;
        $display("FAIL zero_len c%0d: got data/done=%b want %b", c, {data, done},
                 {ed[c], edn[c]});
      end
      @(posedge clk);
      #1;
    end
    trig = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [15:0] tv, ed, edn, eb;
    // Second trig lands exactly in the LOW-exit cycle.
    tv = 16'h0011; ed = 16'h0066; edn = 16'h0088; eb = 16'h01FE;
    high_len = 8'd2; low_len = 8'd2;
    for (int c = 0; c < 12; c++) begin
      trig = tv[c];
      @(negedge clk);
      nvec++;
      if ({data, done, busy} !== {ed[c], edn[c], eb[c]}) begin
        nerr++;
        $display("FAIL simultaneous c%0d: got data/done/busy=%b want %b", c, {data, done, busy},
                 {ed[c], edn[c], eb[c]});
      end
      @(posedge clk);
      #1;
    end
    trig = 1'b0;
  endtask

  task automatic test_overflow();
    int          pulses, dones, ovfs, c;
    logic        prev;
    logic [31:0] eo;
    eo = 32'h001E_0000;  // drops in cycles 16..19 show up one cycle later
    high_len = 8'd10; low_len = 8'd10;
    pulses = 0; dones = 0; ovfs = 0; prev = 1'b0; c = 0;
    while (c < 400 && !(c > 20 && !busy)) begin
      trig = (c < 20);
      @(negedge clk);
      if (data && !prev) pulses++;
      prev = data;
      if (done) dones++;
      if (ovf) ovfs++;
      if (c < 32) begin
        nvec++;
        if (ovf !== eo[c]) begin
          nerr++;
          $display("FAIL overflow_ovf c%0d: got %b want %b", c, ovf, eo[c]);
        end
      end
      @(posedge clk);
      #1;
      c++;
    end
    trig = 1'b0;
    nvec++;
    if (c >= 400) begin
      nerr++;
      $display("FAIL overflow_timeout: got busy after %0d cycles want idle", c);
    end
    nvec++;
    if (pulses != 16) begin
      nerr++;
      $display("FAIL overflow_pulses: got %0d want 16", pulses);
    end
    nvec++;
    if (dones != 16) begin
      nerr++;
      $display("FAIL overflow_dones: got %0d want 16", dones);
    end
    nvec++;
    if (ovfs != 4) begin
      nerr++;
      $display("FAIL overflow_count: got %0d want 4", ovfs);
    end
  endtask

  task automatic test_max_len();
    int highs, dones;
    high_len = 8'd255; low_len = 8'd1;
    highs = 0; dones = 0;
    for (int c = 0; c < 300; c++) begin
      trig = (c == 0);
      @(negedge clk);
      if (data) highs++;
      if (done) dones++;
      @(posedge clk);
      #1;
    end
    trig = 1'b0;
    nvec++;
    if (highs != 255) begin
      nerr++;
      $display("FAIL max_len_high: got %0d cycles want 255", highs);
    end
    nvec++;
    if (dones != 1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL max_len_done: got dones=%0d busy=%b want 1/0", dones, busy);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int highs;
    high_len = 8'd10; low_len = 8'd2;
    for (int c = 0; c < 5; c++) begin
      trig = (c < 4);  // one pulse started plus three queued
      @(posedge clk);
      #1;
    end
    trig = 1'b0;
    nvec++;
    if (data !== 1'b1) begin
      nerr++;
      $display("FAIL mid_pulse_pre: got data=%b want 1", data);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (data !== 1'b0) begin
      nerr++;
      $display("FAIL mid_pulse_async: got data=%b want 0", data);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL mid_pulse_busy: got %b want 0", busy);
    end
    highs = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (data) highs++;
    end
    nvec++;
    if (highs != 0) begin
      nerr++;
      $display("FAIL mid_pulse_quiet: got %0d high cycles want 0", highs);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_single();
    test_burst();
    test_zero_len();
    test_simultaneous();
    test_overflow();
    test_max_len();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
